// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB pipeline stage: write-back selector, load
// funct3 encodings and the packed entry held in the WB register.
package wb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned INSTRET_W = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic [REG_IDX_W-1:0] rd_idx;
        wb_sel_e              wb_sel;
        logic [2:0]           funct3;
        logic [1:0]           addr_lo;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      mem_rdata;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: entry fields and pipeline controls coming from MEM,
// register-file write port and status going out of WB.
//   master : MEM side / bench, drives in_* and stall/flush
//   slave  : the WB stage, drives wr_* / wb_valid / load_fault
interface mem_wb_stage_if;
    import wb_pkg::*;

    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic                 in_reg_write;
    logic [REG_IDX_W-1:0] in_rd_idx;
    logic [1:0]           in_wb_sel;
    logic [2:0]           in_funct3;
    logic [XLEN-1:0]      in_alu_result;
    logic [XLEN-1:0]      in_pc_plus4;
    logic [XLEN-1:0]      in_mem_rdata;
    logic [1:0]           in_addr_lo;

    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_idx;
    logic [XLEN-1:0]      wr_data;
    logic                 wb_valid;
    logic                 load_fault;

    modport master (
        output in_valid, stall, flush, in_reg_write, in_rd_idx, in_wb_sel,
               in_funct3, in_alu_result, in_pc_plus4, in_mem_rdata, in_addr_lo,
        input  wr_en, wr_idx, wr_data, wb_valid, load_fault
    );

    modport slave (
        input  in_valid, stall, flush, in_reg_write, in_rd_idx, in_wb_sel,
               in_funct3, in_alu_result, in_pc_plus4, in_mem_rdata, in_addr_lo,
        output wr_en, wr_idx, wr_data, wb_valid, load_fault
    );

endinterface

// File: rtl/load_align.sv
// Combinational load formatter: selects byte/half from the aligned word,
// sign/zero-extends, and flags misaligned or unsupported load types.
//   funct3, addr_lo, mem_rdata  -> load_data_c, misalign_c, illegal_c
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] load_data_c,
    output logic            misalign_c,
    output logic            illegal_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = 8'(mem_rdata >> {addr_lo, 3'b000});
        half_v      = 16'(mem_rdata >> {addr_lo[1], 4'b0000});
        load_data_c = '0;
        misalign_c  = 1'b0;
        illegal_c   = 1'b0;
        case (funct3)
            LB:  load_data_c = {{24{byte_v[7]}}, byte_v};
            LBU: load_data_c = {24'h0, byte_v};
            LH: begin
                load_data_c = {{16{half_v[15]}}, half_v};
                misalign_c  = addr_lo[0];
            end
            LHU: begin
                load_data_c = {16'h0, half_v};
                misalign_c  = addr_lo[0];
            end
            LW: begin
                load_data_c = mem_rdata;
                misalign_c  = (addr_lo != 2'b00);
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back mux.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_wb_stage_if.slave (entry in, register-file write out)
//   instret    : retired-instruction counter, present only when
//                MEM_WB_INSTRET_EN is defined
module mem_wb_stage
    import wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
`ifdef MEM_WB_INSTRET_EN
    output logic [INSTRET_W-1:0] instret,
`endif
    mem_wb_stage_if.slave        bus
);

    wb_entry_t       entry_q;
    wb_entry_t       entry_d;
    logic [XLEN-1:0] load_data;
    logic            misalign;
    logic            illegal;
    logic            load_fault;

    // Entry update: flush kills validity even under stall, stall holds all.
    always_comb begin
        entry_d = entry_q;
        if (bus.flush) begin
            entry_d.valid = 1'b0;
        end else if (!bus.stall) begin
            entry_d.valid      = bus.in_valid;
            entry_d.reg_write  = bus.in_reg_write;
            entry_d.rd_idx     = bus.in_rd_idx;
            entry_d.wb_sel     = wb_sel_e'(bus.in_wb_sel);
            entry_d.funct3     = bus.in_funct3;
            entry_d.addr_lo    = bus.in_addr_lo;
            entry_d.alu_result = bus.in_alu_result;
            entry_d.pc_plus4   = bus.in_pc_plus4;
            entry_d.mem_rdata  = bus.in_mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    load_align u_load_align (
        .funct3      (entry_q.funct3),
        .addr_lo     (entry_q.addr_lo),
        .mem_rdata   (entry_q.mem_rdata),
        .load_data_c (load_data),
        .misalign_c  (misalign),
        .illegal_c   (illegal)
    );

    assign load_fault = entry_q.valid && (entry_q.wb_sel == WB_MEM) && (misalign || illegal);

    // Write-back data mux; reserved selector yields zero.
    always_comb begin
        case (entry_q.wb_sel)
            WB_ALU:  bus.wr_data = entry_q.alu_result;
            WB_MEM:  bus.wr_data = load_data;
            WB_PC4:  bus.wr_data = entry_q.pc_plus4;
            default: bus.wr_data = '0;
        endcase
    end

    // Write is suppressed while stalled so a held entry commits only once.
    assign bus.wr_en = entry_q.valid && entry_q.reg_write && (entry_q.rd_idx != '0)
                     && (entry_q.wb_sel != WB_RSVD) && !load_fault && !bus.stall;
    assign bus.wr_idx     = entry_q.rd_idx;
    assign bus.wb_valid   = entry_q.valid;
    assign bus.load_fault = load_fault;

`ifdef MEM_WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (entry_q.valid && !bus.stall && !load_fault) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have inputs: in_valid 1 (MEM entry valid); stall 1 (pipeline freeze); flush 1 (kill entry); in_reg_write 1; in_rd_idx 5; in_wb_sel 2; in_funct3 3 (load type); in_alu_result 32; in_pc_plus4 32; in_mem_rdata 32 (raw aligned word); in_addr_lo 2 (load byte offset).
REQ-003 SHALL have outputs: wr_en 1, wr_idx 5, wr_data 32 (register-file write port); wb_valid 1 (entry occupying WB); load_fault 1 (faulting load in WB).

Function
REQ-004 SHALL hold one registered entry: valid, reg_write, rd_idx, wb_sel, funct3, addr_lo, alu_result, pc_plus4, mem_rdata.
REQ-005 SHALL capture all inputs at posedge when !stall && !flush; valid captures in_valid.
REQ-006 flush SHALL clear valid at next posedge regardless of stall; flush beats stall.
REQ-007 stall && !flush SHALL hold every entry field unchanged.
REQ-008 Latency: input at edge N appears on wr_* during cycle N+1; register file commits at edge N+2.
REQ-009 wb_valid SHALL equal registered valid.
REQ-010 wr_data SHALL be combinational from entry: WB_ALU -> alu_result; WB_MEM -> formatted load; WB_PC4 -> pc_plus4; WB_RSVD -> 32'h0.
REQ-011 Load formatting: byte = mem_rdata[8*addr_lo +: 8], half = mem_rdata[16*addr_lo[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-012 load_fault SHALL = valid && wb_sel==WB_MEM && (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0, or funct3 in {011,110,111}).
REQ-013 wr_en SHALL = valid && reg_write && rd_idx!=0 && wb_sel!=WB_RSVD && !load_fault && !stall.
REQ-014 wr_idx SHALL = rd_idx always; wr_data undefined-free (deterministic) when wr_en=0.
REQ-015 A stalled entry SHALL assert wr_en exactly once: in the first non-stall cycle it is resident.
REQ-016 Back-to-back valid inputs without stall SHALL produce one write per cycle, no bubble.

Reset
REQ-017 reset SHALL clear valid and all entry fields to 0 at posedge; beats flush and stall.
REQ-018 During/after reset cycle: wr_en=0, wr_idx=0, wr_data=0, wb_valid=0, load_fault=0.
REQ-019 Reset mid-stall SHALL discard the held entry; no write issued for it.

Configuration
REQ-020 Macro MEM_WB_INSTRET_EN SHALL, when defined, add output instret  out  64  retired-instruction count.
REQ-021 With macro: instret resets to 0, increments by 1 each cycle valid && !stall && !load_fault, wraps 2^64-1 -> 0.
REQ-022 Without macro: no instret port, no counter logic.

Structure
REQ-023 Package wb_pkg SHALL hold wb_sel_e (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_RSVD=3) and funct3 load constants (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-024 Sub-module load_align (combinational: funct3, addr_lo, mem_rdata -> formatted data, misalign/illegal) SHALL implement REQ-011/012.

Verification
REQ-025 ALU write: in_valid, reg_write, rd=5, WB_ALU, alu=0x1234_5678 -> next cycle wr_en=1, wr_idx=5, wr_data=0x1234_5678.
REQ-026 Loads, mem_rdata=0x8081_F27F: LB off3 -> 0xFFFF_FF80; LBU off0 -> 0x0000_007F; LH off2 -> 0xFFFF_8081; LHU off0 -> 0x0000_F27F.
REQ-027 Fault: LW off2, rd=7 -> load_fault=1, wr_en=0; instret unchanged.
REQ-028 Stall 3 cycles on PC4 entry rd=1, pc_plus4=0x104 -> wr_en=0 while stalled, single wr_en=1 with 0x104 on release; instret +1 once.
REQ-029 flush with stall same cycle -> wb_valid=0 next cycle; rd=0 entry -> wr_en never asserts.
REQ-030 reset asserted while valid entry held -> next cycle all outputs 0, instret=0.
